// File: rtl/standby_mode_sequencer.sv
// -----------------------------------------------------------------------------
// standby_mode_sequencer
//
// Hands the target-transaction interface over between an I2C and an I3C
// standby controller. A mode switch waits for the bus to be idle for
// t_bus_idle_i cycles, then holds both controllers disabled for GapCycles
// cycles before the new mode is enabled and the TTI mux is flipped.
//
// Parameters
//   GapCycles      cycles with both controllers disabled during a switch (1..15)
//   TimeoutCycles  WAIT_IDLE bound, only with STANDBY_SEQ_TIMEOUT_EN defined
//
// Optional feature macro: STANDBY_SEQ_TIMEOUT_EN
//   defined   -> a switch stuck waiting for idle is forced after TimeoutCycles
//   undefined -> WAIT_IDLE is unbounded and timeout_o is tied low
//
// Ports
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   i2c_standby_en_i  I2C standby mode requested
//   i3c_standby_en_i  I3C standby mode requested (wins over I2C)
//   bus_start_i       START pulse from the active controller
//   bus_stop_i        STOP pulse from the active controller
//   scl_i, sda_i      sampled bus lines
//   t_bus_idle_i      required idle duration in clk_i cycles
//   sel_i3c_o         TTI mux select, 1 = I3C controller
//   i2c_en_o          I2C standby controller enable
//   i3c_en_o          I3C standby controller enable
//   switching_o       a mode switch is in progress
//   mode_change_o     one-cycle pulse when a new mode takes effect
//   req_conflict_o    both mode requests are set
//   timeout_o         one-cycle pulse when a switch was forced by timeout
// -----------------------------------------------------------------------------
module standby_mode_sequencer #(
  parameter int unsigned GapCycles     = 2,
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i2c_standby_en_i,
  input  logic        i3c_standby_en_i,
  input  logic        bus_start_i,
  input  logic        bus_stop_i,
  input  logic        scl_i,
  input  logic        sda_i,
  input  logic [19:0] t_bus_idle_i,
  output logic        sel_i3c_o,
  output logic        i2c_en_o,
  output logic        i3c_en_o,
  output logic        switching_o,
  output logic        mode_change_o,
  output logic        req_conflict_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_IDLE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_I2C = 2'd1,
    MODE_I3C = 2'd2
  } mode_t;

  localparam logic [3:0]  GAP_LAST = 4'(GapCycles - 1);
  localparam logic [15:0] TO_LAST  = 16'(TimeoutCycles - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  mode_t       r_cur;
  mode_t       w_cur_nxt;
  mode_t       w_req;
  logic        r_busy;
  logic        w_busy_nxt;
  logic [19:0] r_idle_cnt;
  logic [19:0] w_idle_cnt_nxt;
  logic        w_bus_idle;
  logic [3:0]  r_gap_cnt;
  logic [3:0]  w_gap_cnt_nxt;
  logic        r_mode_change;
  logic        w_mode_change_nxt;
  logic        w_force_timeout;
`ifdef STANDBY_SEQ_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_cnt_nxt;
  logic        r_timeout;
`else
  logic [15:0] w_unused_timeout;
`endif

  // Requested mode: I3C has priority over I2C.
  always_comb begin
    w_req = MODE_OFF;
    if (i3c_standby_en_i) begin
      w_req = MODE_I3C;
    end else if (i2c_standby_en_i) begin
      w_req = MODE_I2C;
    end
  end

  // START wins over a STOP in the same cycle, so the bus stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus_start_i) begin
      w_busy_nxt = 1'b1;
    end else if (bus_stop_i) begin
      w_busy_nxt = 1'b0;
    end
  end

  // Idle counter follows the updated busy flag so that a START (even one
  // paired with a STOP) never counts as an idle cycle.
  always_comb begin
    w_idle_cnt_nxt = '0;
    if (!w_busy_nxt && scl_i && sda_i) begin
      if (r_idle_cnt < t_bus_idle_i) begin
        w_idle_cnt_nxt = r_idle_cnt + 20'd1;
      end else begin
        w_idle_cnt_nxt = t_bus_idle_i;
      end
    end
  end

  // The busy term makes a zero idle requirement mean "not busy".
  assign w_bus_idle = !r_busy && (r_idle_cnt >= t_bus_idle_i);

  // Next-state logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_cur_nxt         = r_cur;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_mode_change_nxt = 1'b0;
    w_force_timeout   = 1'b0;
`ifdef STANDBY_SEQ_TIMEOUT_EN
    w_wait_cnt_nxt    = '0;
`endif
    case (r_state)
      ST_OFF, ST_RUN: begin
        if (w_req != r_cur) begin
          w_state_nxt = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_req == r_cur) begin
          // Request reverted: resume the current mode without a gap.
          w_state_nxt = (r_cur == MODE_OFF) ? ST_OFF : ST_RUN;
        end else if (w_bus_idle) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = '0;
        end
`ifdef STANDBY_SEQ_TIMEOUT_EN
        else if (r_wait_cnt == TO_LAST) begin
          w_state_nxt     = ST_GAP;
          w_gap_cnt_nxt   = '0;
          w_force_timeout = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
`endif
      end
      ST_GAP: begin
        // Gap length is fixed; a request change here only picks the mode
        // that is loaded on exit.
        if (r_gap_cnt == GAP_LAST) begin
          w_cur_nxt         = w_req;
          w_state_nxt       = (w_req == MODE_OFF) ? ST_OFF : ST_RUN;
          w_mode_change_nxt = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_OFF;
      r_cur         <= MODE_OFF;
      r_busy        <= 1'b0;
      r_idle_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_mode_change <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur         <= w_cur_nxt;
      r_busy        <= w_busy_nxt & ~w_force_timeout;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_mode_change <= w_mode_change_nxt;
    end
  end

`ifdef STANDBY_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_force_timeout;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_unused_timeout = TO_LAST;
  assign timeout_o        = 1'b0;
`endif

  // Enables keep their running values while waiting for idle and drop only
  // for the gap.
  assign sel_i3c_o      = (r_cur == MODE_I3C);
  assign i2c_en_o       = (r_state != ST_GAP) && (r_cur == MODE_I2C);
  assign i3c_en_o       = (r_state != ST_GAP) && (r_cur == MODE_I3C);
  assign switching_o    = (r_state == ST_WAIT_IDLE) || (r_state == ST_GAP);
  assign mode_change_o  = r_mode_change;
  assign req_conflict_o = i2c_standby_en_i && i3c_standby_en_i;

endmodule

// File: tb/tb_standby_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_standby_mode_sequencer
//
// Directed scenarios followed by randomized traffic. Every cycle the DUT
// outputs are compared with a behavioural model of the sequencing rules:
// mode as a number, a switching phase (steady / waiting / gap) and plain
// integer counters.
// -----------------------------------------------------------------------------
module tb_standby_mode_sequencer;

  localparam int GAP = 2;
`ifdef STANDBY_SEQ_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i2c_standby_en_i;
  logic        i3c_standby_en_i;
  logic        bus_start_i;
  logic        bus_stop_i;
  logic        scl_i;
  logic        sda_i;
  logic [19:0] t_bus_idle_i;
  logic        sel_i3c_o;
  logic        i2c_en_o;
  logic        i3c_en_o;
  logic        switching_o;
  logic        mode_change_o;
  logic        req_conflict_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0=OFF 1=I2C 2=I3C; phase 0=steady 1=waiting 2=gap.
  int m_mode, m_phase, m_gap_left, m_idle, m_wait;
  bit m_busy, m_mc, m_to;

  // Output snapshot of the most recent cycle.
  logic s_sel, s_i2c, s_i3c, s_sw, s_mc, s_conf, s_to;

  standby_mode_sequencer #(
    .GapCycles     (GAP),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .i2c_standby_en_i (i2c_standby_en_i),
    .i3c_standby_en_i (i3c_standby_en_i),
    .bus_start_i      (bus_start_i),
    .bus_stop_i       (bus_stop_i),
    .scl_i            (scl_i),
    .sda_i            (sda_i),
    .t_bus_idle_i     (t_bus_idle_i),
    .sel_i3c_o        (sel_i3c_o),
    .i2c_en_o         (i2c_en_o),
    .i3c_en_o         (i3c_en_o),
    .switching_o      (switching_o),
    .mode_change_o    (mode_change_o),
    .req_conflict_o   (req_conflict_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_gap_left = 0; m_idle = 0; m_wait = 0;
    m_busy = 1'b0; m_mc = 1'b0; m_to = 1'b0;
  endtask

  // One clock cycle: apply inputs, compare at the falling edge, advance model.
  task automatic cyc(input bit rst, input bit i2c, input bit i3c, input bit st,
                     input bit sp, input bit scl, input bit sda, input int t);
    int req;
    int ni;
    bit nb;
    bit idle_ok;
    rst_i = rst; i2c_standby_en_i = i2c; i3c_standby_en_i = i3c;
    bus_start_i = st; bus_stop_i = sp; scl_i = scl; sda_i = sda;
    t_bus_idle_i = 20'(t);
    @(negedge clk_i);
    s_sel = sel_i3c_o; s_i2c = i2c_en_o; s_i3c = i3c_en_o; s_sw = switching_o;
    s_mc = mode_change_o; s_conf = req_conflict_o; s_to = timeout_o;
    chk("sel_i3c",  32'(sel_i3c_o),      32'(m_mode == 2));
    chk("i2c_en",   32'(i2c_en_o),       32'(m_phase != 2 && m_mode == 1));
    chk("i3c_en",   32'(i3c_en_o),       32'(m_phase != 2 && m_mode == 2));
    chk("switch",   32'(switching_o),    32'(m_phase != 0));
    chk("mchange",  32'(mode_change_o),  32'(m_mc));
    chk("conflict", 32'(req_conflict_o), 32'(i2c && i3c));
    chk("timeout",  32'(timeout_o),      32'(m_to));
    if (rst) begin
      model_reset();
    end else begin
      req     = i3c ? 2 : (i2c ? 1 : 0);
      idle_ok = !m_busy && (m_idle >= t);
      nb      = st ? 1'b1 : (sp ? 1'b0 : m_busy);
      if (!nb && scl && sda) ni = (m_idle < t) ? m_idle + 1 : t;
      else                   ni = 0;
      m_mc = 1'b0;
      m_to = 1'b0;
      case (m_phase)
        0: begin
          if (req != m_mode) begin
            m_phase = 1;
`ifdef STANDBY_SEQ_TIMEOUT_EN
            m_wait = 0;
`endif
          end
        end
        1: begin
          if (req == m_mode) m_phase = 0;
          else if (idle_ok) begin m_phase = 2; m_gap_left = GAP; end
`ifdef STANDBY_SEQ_TIMEOUT_EN
          else if (m_wait == TO - 1) begin
            m_phase = 2; m_gap_left = GAP; m_to = 1'b1; nb = 1'b0;
          end else m_wait++;
`endif
        end
        default: begin
          m_gap_left--;
          if (m_gap_left == 0) begin
            m_mode = req; m_mc = 1'b1; m_phase = 0;
          end
        end
      endcase
      m_busy = nb;
      m_idle = ni;
    end
    @(posedge clk_i);
    #1;
  endtask

  logic [1:0]  r_req;
  int          r_t;
  bit          r_st, r_sp, r_scl, r_sda, r_rst;

  initial begin
    rst_i = 1'b1; i2c_standby_en_i = 1'b0; i3c_standby_en_i = 1'b0;
    bus_start_i = 1'b0; bus_stop_i = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
    t_bus_idle_i = 20'd10;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();

    // Reset state.
    cyc(1, 0, 0, 0, 0, 1, 1, 10);
    chk("rst_outputs", 32'({s_sel, s_i2c, s_i3c, s_sw, s_mc, s_to}), 32'd0);

    // First switch to I3C: gap starts 11 cycles after the request.
    for (int k = 0; k <= 14; k++) begin
      cyc(0, 0, 1, 0, 0, 1, 1, 10);
      chk("up_switching", 32'(s_sw),  32'(k >= 1 && k <= 12));
      chk("up_i3c_en",    32'(s_i3c), 32'(k >= 13));
      chk("up_sel",       32'(s_sel), 32'(k >= 13));
      chk("up_mchange",   32'(s_mc),  32'(k == 13));
    end

    // Busy bus holds an I3C->I2C switch in WAIT_IDLE.
    cyc(0, 0, 1, 1, 0, 1, 1, 10);
    for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 0, 1, 1, 10);
    chk("busy_wait_sw",  32'(s_sw),  32'd1);
    chk("busy_wait_i3c", 32'(s_i3c), 32'd1);
    for (int k = 0; k <= 13; k++) begin
      cyc(0, 1, 0, 0, (k == 0), 1, 1, 10);
      if (k == 10) chk("stop_pre_gap_i3c", 32'(s_i3c), 32'd1);
      if (k == 11) chk("stop_gap_en", 32'({s_i2c, s_i3c}), 32'd0);
      if (k == 13) chk("stop_i2c_mode", 32'({s_i2c, s_sel, s_mc}), 32'b101);
    end

    // Revert the request while waiting: no gap, no pulse.
    cyc(0, 1, 0, 1, 0, 1, 1, 10);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 0, 1, 1, 10);
    chk("revert_wait", 32'({s_sw, s_i2c}), 32'b11);
    cyc(0, 1, 0, 0, 0, 1, 1, 10);
    cyc(0, 1, 0, 0, 0, 1, 1, 10);
    chk("revert_done", 32'({s_sw, s_mc, s_i2c, s_sel}), 32'b0010);
    cyc(0, 1, 0, 0, 1, 1, 1, 10);

    // Both requests: conflict flagged and I3C selected.
    for (int k = 0; k < 16; k++) cyc(0, 1, 1, 0, 0, 1, 1, 10);
    chk("conflict_flag", 32'(s_conf), 32'd1);
    chk("conflict_i3c",  32'({s_i3c, s_sel}), 32'b11);

    // START and STOP together leave the bus busy even with a 1-cycle idle need.
    cyc(0, 0, 1, 1, 1, 1, 1, 1);
    for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0, 1, 1, 1);
    chk("startstop_busy", 32'({s_sw, s_i3c}), 32'b11);
    cyc(0, 1, 0, 0, 1, 1, 1, 1);
    for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0, 1, 1, 1);
    chk("startstop_done", 32'({s_i2c, s_sw}), 32'b10);

    // Reset in the middle of a gap (zero idle requirement).
    cyc(0, 0, 1, 0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 0, 1, 1, 0);
    chk("gap_before_rst", 32'({s_sw, s_i2c, s_i3c}), 32'b100);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    chk("rst_mid_gap", 32'({s_sel, s_i2c, s_i3c, s_sw, s_mc, s_conf, s_to}), 32'd0);

`ifdef STANDBY_SEQ_TIMEOUT_EN
    // Bus held busy: the switch is forced after TO cycles of waiting.
    cyc(0, 0, 0, 1, 0, 1, 1, 10);
    for (int k = 0; k <= 102; k++) begin
      cyc(0, 0, 1, 0, 0, 1, 1, 10);
      chk("to_pulse", 32'(s_to), 32'(k == 101));
      if (k == 101) chk("to_gap", 32'({s_sw, s_i3c}), 32'b10);
    end
`endif

    // Randomized traffic.
    r_req = 2'd0;
    r_t   = 4;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0)  r_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) r_t = int'($urandom_range(0, 12));
      r_st  = ($urandom_range(0, 15) == 0);
      r_sp  = ($urandom_range(0, 7) == 0);
      r_scl = ($urandom_range(0, 15) != 0);
      r_sda = ($urandom_range(0, 15) != 0);
      r_rst = ($urandom_range(0, 399) == 0);
      cyc(r_rst, r_req[0], r_req[1], r_st, r_sp, r_scl, r_sda, r_t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
